uart_bus_host: RTL and testbench
================================

// Module: uart_bus_host
// PURPOSE
//  Serial-to-bus bridge: receives 8N1 command frames on a UART line and acts as initiator on the
//  device bus (req/addr/we/be/wdata -> rvalid/rdata), the opposite end to memory-mapped responders.
//  Used as a debug/loader port that pokes and peeks device registers without the CPU.
//  Returns read data or status bytes over its own 8N1 transmitter.
// PARAMETERS
//  ClockFrequency  50_000_000  clk_i frequency in Hz
//  BaudRate        115_200     line rate; ClocksPerBaud = ClockFrequency / BaudRate (integer, >= 4)
//  TimeoutCycles   1024        bus response timeout in clk_i cycles (used only with macro below)
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   reset, asynchronous, active-low
//  uart_rx_i     in   1   serial command input, idle high, asynchronous (3-flop synchronised)
//  uart_tx_o     out  1   serial response output, idle high
//  host_req_o    out  1   bus request, one-cycle pulse per transaction
//  host_addr_o   out  32  bus address
//  host_we_o     out  1   1 = write, 0 = read
//  host_be_o     out  4   byte enables, always 4'hF while host_req_o = 1
//  host_wdata_o  out  32  write data
//  host_rvalid_i in   1   responder completion (reads and writes)
//  host_rdata_i  in   32  read data, valid with host_rvalid_i
//  busy_o        out  1   1 whenever the command FSM is not in IDLE
// BEHAVIOUR
//  Reset: uart_tx_o=1; host_req_o=0, host_we_o=0, host_be_o=0, host_addr_o=0, host_wdata_o=0, busy_o=0; all FSMs IDLE.
//  RX: falling edge on synchronised line in RX idle starts frame; baud counter preset to ClocksPerBaud/2
//   so bits are sampled mid-bit; start bit re-checked low at mid-bit (high -> glitch, back to idle);
//   8 data bits LSB first; stop bit sampled: 1 -> one-cycle rx_byte_valid, 0 -> one-cycle rx_frame_err.
//  TX: 8N1, LSB first, one bit per ClocksPerBaud; loads next queued byte at stop end with no idle gap.
//  Command FSM states: IDLE, ADDR, DATA, REQ, WAIT, RESP.
//   IDLE: byte 0x57 'W' or 0x52 'R' -> ADDR (latch we); any other byte -> RESP with 0x3F '?'.
//   ADDR: collect 4 bytes little-endian into host_addr_o; after 4th: W -> DATA, R -> REQ.
//   DATA: collect 4 bytes little-endian into host_wdata_o; after 4th -> REQ.
//   REQ: host_req_o=1, host_be_o=4'hF for exactly one cycle -> WAIT. addr/we/wdata held stable until next command.
//   WAIT: host_rvalid_i (earliest the cycle after REQ) -> RESP; read: rdata captured that cycle,
//    reply 4 bytes LE; write: reply 0x4B 'K'. rdata ignored on writes.
//   RESP: transmit queued reply bytes; after last stop bit completes -> IDLE.
//  host_rvalid_i outside WAIT is ignored. RX bytes arriving in REQ/WAIT/RESP are discarded.
//  rx_frame_err in ADDR/DATA: abort command, no reply, -> IDLE; in IDLE: ignored.
//  Reset asserted mid-transaction: all outputs to reset values immediately; partial command lost.
// CONFIGURATION
//  UART_BUS_HOST_TIMEOUT_EN defined: counter starts on entering WAIT; if host_rvalid_i not seen within
//   TimeoutCycles cycles -> RESP with single byte 0x54 'T'; late rvalid then ignored.
//  Not defined: WAIT holds indefinitely until host_rvalid_i; TimeoutCycles unused.
// TESTING (ClockFrequency=800, BaudRate=100 -> 8 clk/bit)
//  Send 57 10 00 00 80 EF BE AD DE -> one req, addr 0x8000_0010, we=1, be=F, wdata 0xDEAD_BEEF; rvalid -> TX 0x4B.
//  Send 52 08 00 00 80; respond rvalid 3 cycles later with rdata 0x1234_5678 -> TX 78 56 34 12, busy_o low after.
//  Send 0x41 -> TX 0x3F, no host_req_o pulse.
//  Send 52 08, then byte with stop bit 0 -> no req, no TX, busy_o=0; next 52 .. read completes normally.
//  With UART_BUS_HOST_TIMEOUT_EN, TimeoutCycles=16: read, never assert rvalid -> TX 0x54; rvalid later ignored.
//  Two back-to-back write commands, no gap on uart_rx_i -> two req pulses, two 0x4B replies in order.

Source files
------------

// File: rtl/uart_bus_host.sv
// uart_bus_host: 8N1 UART command port that acts as an initiator on the device bus.
// Commands: 'W' addr[4 LE] data[4 LE] -> 'K'; 'R' addr[4 LE] -> rdata[4 LE]; other -> '?'.
// Optional feature macro: UART_BUS_HOST_TIMEOUT_EN (bounds the bus wait, replies 'T').
`timescale 1ns/1ps
module uart_bus_host #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        host_req_o,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  output logic        busy_o
);
  localparam int unsigned ClocksPerBaud = ClockFrequency / BaudRate;
  localparam int unsigned CntW          = $clog2(ClocksPerBaud);
  localparam logic [CntW-1:0] BaudLast  = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] BaudHalf  = CntW'(ClocksPerBaud / 2);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  if (ClocksPerBaud < 4) begin : g_bad_baud
    $error("uart_bus_host: ClockFrequency / BaudRate must be at least 4");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("uart_bus_host: TimeoutCycles must be at least 1");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP} cmd_state_e;

  // ---------------- receiver ----------------
  logic [2:0]      rx_sync_reg;
  logic            rx_prev_reg;
  rx_state_e       rx_state_reg;
  logic [CntW-1:0] rx_cnt_reg;
  logic [2:0]      rx_bit_reg;
  logic [7:0]      rx_shift_reg;
  logic            rx_valid_reg;
  logic            rx_err_reg;
  logic            rx_line;

  assign rx_line = rx_sync_reg[2];

  // Synchronise the line, find the start edge and sample each bit at mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_reg  <= 3'b111;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[1:0], uart_rx_i};
      rx_prev_reg  <= rx_line;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: if (rx_prev_reg && !rx_line) begin
          rx_cnt_reg   <= BaudHalf;
          rx_state_reg <= RX_START;
        end
        RX_START: if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - CntOne;
          else if (rx_line) rx_state_reg <= RX_IDLE;   // glitch, not a real start bit
          else begin
            rx_cnt_reg   <= BaudLast;
            rx_bit_reg   <= '0;
            rx_state_reg <= RX_DATA;
          end
        RX_DATA: if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - CntOne;
          else begin
            rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
            rx_cnt_reg   <= BaudLast;
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end
        default: if (rx_cnt_reg != '0) rx_cnt_reg <= rx_cnt_reg - CntOne;
          else begin
            rx_valid_reg <= rx_line;
            rx_err_reg   <= !rx_line;
            rx_state_reg <= RX_IDLE;
          end
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic            tx_active_reg;
  logic [9:0]      tx_shift_reg;
  logic [3:0]      tx_bit_reg;
  logic [CntW-1:0] tx_cnt_reg;
  logic [23:0]     tx_queue_reg;
  logic [1:0]      tx_left_reg;
  logic            tx_load_reg;
  logic [31:0]     tx_load_data_reg;
  logic [1:0]      tx_load_left_reg;
  logic            tx_last_stop;

  assign uart_tx_o    = tx_shift_reg[0];
  assign tx_last_stop = tx_active_reg && (tx_bit_reg == 4'd9) && (tx_left_reg == 2'd0);

  // Shift out queued reply bytes back to back, one bit per baud period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_active_reg <= 1'b0;
      tx_shift_reg  <= '1;
      tx_bit_reg    <= '0;
      tx_cnt_reg    <= '0;
      tx_queue_reg  <= '0;
      tx_left_reg   <= '0;
    end else if (tx_load_reg && !tx_active_reg) begin
      tx_shift_reg  <= {1'b1, tx_load_data_reg[7:0], 1'b0};
      tx_queue_reg  <= tx_load_data_reg[31:8];
      tx_left_reg   <= tx_load_left_reg;
      tx_bit_reg    <= '0;
      tx_cnt_reg    <= BaudLast;
      tx_active_reg <= 1'b1;
    end else if (tx_active_reg) begin
      if (tx_cnt_reg != '0) tx_cnt_reg <= tx_cnt_reg - CntOne;
      else begin
        tx_cnt_reg <= BaudLast;
        if (tx_bit_reg != 4'd9) begin
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
          tx_bit_reg   <= tx_bit_reg + 4'd1;
        end else if (tx_left_reg != 2'd0) begin
          tx_shift_reg <= {1'b1, tx_queue_reg[7:0], 1'b0};
          tx_queue_reg <= {8'h00, tx_queue_reg[23:8]};
          tx_left_reg  <= tx_left_reg - 2'd1;
          tx_bit_reg   <= '0;
        end else tx_active_reg <= 1'b0;
      end
    end
  end

  // ---------------- command FSM ----------------
  cmd_state_e  state_reg;
  logic [1:0]  byte_cnt_reg;
  logic        pend_reg;
  logic [7:0]  pend_byte_reg;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
`ifdef UART_BUS_HOST_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_reg;
`endif

  // A byte whose stop bit lands during the reply's final stop bit is kept for IDLE,
  // so a new command sent with no line gap after the previous one is not lost.
  assign cmd_valid = rx_valid_reg | pend_reg;
  assign cmd_byte  = pend_reg ? pend_byte_reg : rx_shift_reg;
  assign busy_o    = (state_reg != S_IDLE);

  // Parse commands, run one bus transaction and hand the reply to the transmitter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= S_IDLE;
      byte_cnt_reg     <= '0;
      pend_reg         <= 1'b0;
      pend_byte_reg    <= '0;
      host_req_o       <= 1'b0;
      host_addr_o      <= '0;
      host_we_o        <= 1'b0;
      host_be_o        <= '0;
      host_wdata_o     <= '0;
      tx_load_reg      <= 1'b0;
      tx_load_data_reg <= '0;
      tx_load_left_reg <= '0;
`ifdef UART_BUS_HOST_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
`endif
    end else begin
      host_req_o  <= 1'b0;
      host_be_o   <= 4'h0;
      tx_load_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          pend_reg <= 1'b0;
          if (cmd_valid) begin
            if (cmd_byte == 8'h57 || cmd_byte == 8'h52) begin
              host_we_o    <= (cmd_byte == 8'h57);
              byte_cnt_reg <= '0;
              state_reg    <= S_ADDR;
            end else begin
              tx_load_reg      <= 1'b1;
              tx_load_data_reg <= 32'h0000_003F;
              tx_load_left_reg <= 2'd0;
              state_reg        <= S_RESP;
            end
          end
        end
        S_ADDR: if (rx_err_reg) state_reg <= S_IDLE;
          else if (rx_valid_reg) begin
            host_addr_o  <= {rx_shift_reg, host_addr_o[31:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (host_we_o) state_reg <= S_DATA;
              else begin
                host_req_o <= 1'b1;
                host_be_o  <= 4'hF;
                state_reg  <= S_REQ;
              end
            end
          end
        S_DATA: if (rx_err_reg) state_reg <= S_IDLE;
          else if (rx_valid_reg) begin
            host_wdata_o <= {rx_shift_reg, host_wdata_o[31:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              host_req_o <= 1'b1;
              host_be_o  <= 4'hF;
              state_reg  <= S_REQ;
            end
          end
        S_REQ: begin
`ifdef UART_BUS_HOST_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          state_reg <= S_WAIT;
        end
        S_WAIT: if (host_rvalid_i) begin
            tx_load_reg      <= 1'b1;
            tx_load_data_reg <= host_we_o ? 32'h0000_004B : host_rdata_i;
            tx_load_left_reg <= host_we_o ? 2'd0 : 2'd3;
            state_reg        <= S_RESP;
          end
`ifdef UART_BUS_HOST_TIMEOUT_EN
          else if (tmo_cnt_reg == TmoW'(TimeoutCycles - 1)) begin
            tx_load_reg      <= 1'b1;
            tx_load_data_reg <= 32'h0000_0054;
            tx_load_left_reg <= 2'd0;
            state_reg        <= S_RESP;
          end else tmo_cnt_reg <= tmo_cnt_reg + TmoW'(1);
`endif
        S_RESP: begin
          if (rx_valid_reg && tx_last_stop) begin
            pend_reg      <= 1'b1;
            pend_byte_reg <= rx_shift_reg;
          end
          if (!tx_load_reg && !tx_active_reg) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_host.sv
// Bench for uart_bus_host at 8 clocks per bit: directed and random commands against a
// byte-level model of the command protocol.
`timescale 1ns/1ps
module tb_uart_bus_host;
  localparam int Cpb = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic        host_req_o;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = 32'h0;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  uart_bus_host #(.ClockFrequency(800), .BaudRate(100), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_we_o(host_we_o),
    .host_be_o(host_be_o), .host_wdata_o(host_wdata_o), .host_rvalid_i(host_rvalid_i),
    .host_rdata_i(host_rdata_i), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int req_count = 0;
  logic [7:0] tx_bytes[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Serial receiver for the DUT's reply line.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      if (rst_ni && uart_tx_o == 1'b0) begin
        repeat (Cpb / 2) @(negedge clk_i);
        if (uart_tx_o == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (Cpb) @(negedge clk_i);
            b[i] = uart_tx_o;
          end
          repeat (Cpb) @(negedge clk_i);
          chk("tx_stop_bit", 32'(uart_tx_o), 32'd1);
          tx_bytes.push_back(b);
        end
      end
    end
  end

  // Count bus request pulses.
  initial begin : req_monitor
    forever begin
      @(negedge clk_i);
      if (host_req_o === 1'b1) req_count++;
    end
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (Cpb) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (Cpb) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (Cpb) @(negedge clk_i);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit with_data);
    send_byte(op, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) % 256), 1'b1);
    if (with_data)
      for (int i = 0; i < 4; i++) send_byte(8'((wdata >> (8 * i)) % 256), 1'b1);
  endtask

  // Expected reply for a completed command: 'K' for writes, rdata LSB first for reads, '?' otherwise.
  task automatic model_reply(input logic [7:0] op, input logic [31:0] rdata);
    exp_q.delete();
    if (op == 8'h57) exp_q.push_back(8'h4B);
    else if (op == 8'h52)
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata / (32'd1 << (8 * i))) % 256));
    else exp_q.push_back(8'h3F);
  endtask

  // Wait for the request, check it, then complete it after dly cycles.
  task automatic handle_bus(input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata, input int dly);
    bit seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk_i);
      if (host_req_o === 1'b1) seen = 1;
    end
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("req_addr", host_addr_o, exp_addr);
    chk("req_we", 32'(host_we_o), 32'(exp_we));
    chk("req_be", 32'(host_be_o), 32'hF);
    if (exp_we) chk("req_wdata", host_wdata_o, exp_wdata);
    for (int c = 0; c < dly; c++) begin
      @(negedge clk_i);
      if (c == 0) chk("req_one_cycle", 32'(host_req_o), 32'd0);
    end
    host_rvalid_i = 1'b1;
    host_rdata_i  = rdata;
    @(negedge clk_i);
    host_rvalid_i = 1'b0;
    host_rdata_i  = $urandom;
  endtask

  task automatic expect_reply();
    int n = exp_q.size();
    for (int c = 0; c < n * Cpb * 12 + 200 && tx_bytes.size() < n; c++) @(negedge clk_i);
    chk("reply_len", 32'(tx_bytes.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (tx_bytes.size() > 0) chk("reply_byte", 32'(tx_bytes.pop_front()), 32'(exp_q[i]));
    for (int c = 0; c < 40 && busy_o; c++) @(negedge clk_i);
    chk("busy_after_reply", 32'(busy_o), 32'd0);
  endtask

  initial begin : main
    logic [7:0]  op;
    logic [31:0] a, d, r, a2, d2;
    int base;
    bit is_w;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(uart_tx_o), 32'd1);
    chk("rst_req", 32'(host_req_o), 32'd0);
    chk("rst_we", 32'(host_we_o), 32'd0);
    chk("rst_be", 32'(host_be_o), 32'd0);
    chk("rst_addr", host_addr_o, 32'd0);
    chk("rst_wdata", host_wdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);

    // Directed write
    send_cmd(8'h57, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    handle_bus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, $urandom, 2);
    model_reply(8'h57, 32'h0);
    expect_reply();

    // Directed read, response 3 cycles after the request
    send_cmd(8'h52, 32'h8000_0008, 32'h0, 1'b0);
    handle_bus(1'b0, 32'h8000_0008, 32'h0, 32'h1234_5678, 3);
    model_reply(8'h52, 32'h1234_5678);
    expect_reply();

    // Random reads and writes
    for (int k = 0; k < 6; k++) begin
      is_w = 1'($urandom_range(0, 1));
      op = is_w ? 8'h57 : 8'h52;
      a = $urandom; d = $urandom; r = $urandom;
      send_cmd(op, a, d, is_w);
      handle_bus(is_w, a, d, r, $urandom_range(1, 6));
      model_reply(op, r);
      expect_reply();
      $display("cmd %0d: op=%02h addr=%08h wdata=%08h rdata=%08h", k, op, a, d, r);
    end

    // Unknown opcodes
    for (int k = 0; k < 3; k++) begin
      op = 8'h41;
      if (k != 0) begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
      end
      base = req_count;
      send_byte(op, 1'b1);
      model_reply(op, 32'h0);
      expect_reply();
      chk("bad_op_no_req", 32'(req_count), 32'(base));
    end

    // Framing error mid-address aborts silently
    base = req_count;
    send_byte(8'h52, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'($urandom), 1'b0);
    repeat (200) @(negedge clk_i);
    chk("ferr_busy", 32'(busy_o), 32'd0);
    chk("ferr_no_tx", 32'(tx_bytes.size()), 32'd0);
    chk("ferr_no_req", 32'(req_count), 32'(base));
    a = $urandom; r = $urandom;
    send_cmd(8'h52, a, 32'h0, 1'b0);
    handle_bus(1'b0, a, 32'h0, r, 2);
    model_reply(8'h52, r);
    expect_reply();

    // rvalid while idle is ignored
    host_rvalid_i = 1'b1;
    @(negedge clk_i);
    host_rvalid_i = 1'b0;
    repeat (150) @(negedge clk_i);
    chk("idle_rvalid_no_tx", 32'(tx_bytes.size()), 32'd0);
    chk("idle_rvalid_busy", 32'(busy_o), 32'd0);

    // Two writes back to back with no line gap
    base = req_count;
    a = $urandom; d = $urandom; a2 = $urandom; d2 = $urandom;
    send_cmd(8'h57, a, d, 1'b1);
    fork
      send_cmd(8'h57, a2, d2, 1'b1);
      handle_bus(1'b1, a, d, $urandom, 1);
    join
    handle_bus(1'b1, a2, d2, $urandom, 1);
    exp_q.delete();
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h4B);
    expect_reply();
    chk("b2b_req_count", 32'(req_count - base), 32'd2);

    // Reset in the middle of a command
    send_byte(8'h52, 1'b1);
    send_byte(8'($urandom), 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_addr", host_addr_o, 32'd0);
    chk("mid_rst_wdata", host_wdata_o, 32'd0);
    chk("mid_rst_we", 32'(host_we_o), 32'd0);
    chk("mid_rst_tx", 32'(uart_tx_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    a = $urandom; r = $urandom;
    send_cmd(8'h52, a, 32'h0, 1'b0);
    handle_bus(1'b0, a, 32'h0, r, 4);
    model_reply(8'h52, r);
    expect_reply();

`ifdef UART_BUS_HOST_TIMEOUT_EN
    // Bus never answers: 'T' reply, later rvalid ignored
    begin
      bit seen = 0;
      a = $urandom;
      send_cmd(8'h52, a, 32'h0, 1'b0);
      for (int c = 0; c < 400 && !seen; c++) begin
        @(negedge clk_i);
        if (host_req_o === 1'b1) seen = 1;
      end
      chk("tmo_req_seen", 32'(seen), 32'd1);
      exp_q.delete();
      exp_q.push_back(8'h54);
      expect_reply();
      host_rvalid_i = 1'b1;
      @(negedge clk_i);
      host_rvalid_i = 1'b0;
      repeat (150) @(negedge clk_i);
      chk("tmo_late_rvalid_no_tx", 32'(tx_bytes.size()), 32'd0);
      chk("tmo_late_rvalid_busy", 32'(busy_o), 32'd0);
    end
`endif

    repeat (20) @(negedge clk_i);
    chk("no_stray_tx", 32'(tx_bytes.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
